// File: rtl/alt_vipvfr131_common_stream_output_if.sv
// alt_vipvfr131_common_stream_output_if: valid/ready video word stream with packet delimiters
interface alt_vipvfr131_common_stream_output_if #(
    parameter int DATA_WIDTH = 10
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;

    modport master (output valid, data, sop, eop, input ready);
    modport slave  (input valid, data, sop, eop, output ready);
endinterface

// File: rtl/alt_vipvfr131_common_stream_output.sv
// alt_vipvfr131_common_stream_output: buffered Avalon-ST video transmitter with packet-boundary stop
module alt_vipvfr131_common_stream_output #(
    parameter int DATA_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    alt_vipvfr131_common_stream_output_if.slave  int_s,
    alt_vipvfr131_common_stream_output_if.master dout_m,
    input  logic stop,
    output logic stopped
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = DATA_WIDTH + 2;

    typedef enum logic [1:0] {RUN, STOPPING, STOPPED} state_t;

    state_t                state_q, state_d;
    logic [WW-1:0]         mem_q [FIFO_DEPTH];
    logic [WW-1:0]         mem_d [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  in_packet_q, in_packet_d;
    logic                  int_ready_q, int_ready_d;
    logic                  stopped_q, stopped_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [DATA_WIDTH-1:0] dout_data_q, dout_data_d;
    logic                  dout_sop_q, dout_sop_d;
    logic                  dout_eop_q, dout_eop_d;
    logic [WW-1:0]         head;
    logic                  push, pop, pop_en, pop_eop;

    // FIFO bookkeeping, output register loading and stop state machine; a stop
    // outside a packet blocks the pop on the very edge it is seen
    always_comb begin
        head         = mem_q[rd_ptr_q];
        push         = int_s.valid && int_ready_q;
        pop_en       = (state_q == STOPPING) || (state_q == RUN && !(stop && !in_packet_q));
        pop          = dout_m.ready && (count_q != '0) && pop_en;
        pop_eop      = pop && head[0];
        mem_d        = mem_q;
        if (push) mem_d[wr_ptr_q] = {int_s.data, int_s.sop, int_s.eop};
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        count_d      = count_q + CW'(push) - CW'(pop);
        int_ready_d  = count_d < CW'(FIFO_DEPTH);
        dout_valid_d = pop;
        dout_data_d  = pop ? head[WW-1:2] : dout_data_q;
        dout_sop_d   = pop ? head[1] : dout_sop_q;
        dout_eop_d   = pop ? head[0] : dout_eop_q;
        in_packet_d  = !pop ? in_packet_q : head[0] ? 1'b0 : head[1] ? 1'b1 : in_packet_q;
        state_d      = RUN;
        case (state_q)
            RUN:      state_d = !stop ? RUN : (!in_packet_q || pop_eop) ? STOPPED : STOPPING;
            STOPPING: state_d = !stop ? RUN : pop_eop ? STOPPED : STOPPING;
            STOPPED:  state_d = stop ? STOPPED : RUN;
            default:  state_d = RUN;
        endcase
        stopped_d    = state_d == STOPPED;
    end

    // state registers, all cleared asynchronously so a reset drops buffered words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_packet_q  <= 1'b0;
            int_ready_q  <= 1'b0;
            stopped_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_packet_q  <= in_packet_d;
            int_ready_q  <= int_ready_d;
            stopped_q    <= stopped_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_sop_q   <= dout_sop_d;
            dout_eop_q   <= dout_eop_d;
        end
    end

    assign int_s.ready  = int_ready_q;
    assign dout_m.valid = dout_valid_q;
    assign dout_m.data  = dout_data_q;
    assign dout_m.sop   = dout_sop_q;
    assign dout_m.eop   = dout_eop_q;
    assign stopped      = stopped_q;
endmodule

// File: tb/tb_alt_vipvfr131_common_stream_output.sv
// tb_alt_vipvfr131_common_stream_output: scoreboard bench for the stream output block
module tb_alt_vipvfr131_common_stream_output;
    localparam int DW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stop = 1'b0;
    logic stopped;
    logic rdy_prev = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   out_cnt = 0;
    int   acc_cnt = 0;
    logic [DW+1:0] sb [$];

    alt_vipvfr131_common_stream_output_if #(.DATA_WIDTH(DW)) in_if ();
    alt_vipvfr131_common_stream_output_if #(.DATA_WIDTH(DW)) dout_if ();

    alt_vipvfr131_common_stream_output #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .int_s   (in_if),
        .dout_m  (dout_if),
        .stop    (stop),
        .stopped (stopped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic s, input logic e);
        in_if.valid = v;
        in_if.data  = d;
        in_if.sop   = s;
        in_if.eop   = e;
    endtask

    always @(posedge clk) rdy_prev <= dout_if.ready;

    // output checking against the scoreboard, then prediction of the coming push
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_if.valid) begin
                out_cnt++;
                chk("ready_latency", 32'(rdy_prev), 32'd1);
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0)
                    chk("dout_word", 32'({dout_if.data, dout_if.sop, dout_if.eop}), 32'(sb.pop_front()));
            end
            if (in_if.valid && in_if.ready) begin
                sb.push_back({in_if.data, in_if.sop, in_if.eop});
                acc_cnt++;
            end
        end
    end

    initial begin
        int base;
        logic [DW-1:0] w4 [7];
        logic [1:0]    se4 [7];
        logic          pat [5];
        w4  = '{10'h100, 10'h101, 10'h102, 10'h103, 10'h104, 10'h200, 10'h201};
        se4 = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        drive(1'b0, '0, 1'b0, 1'b0);
        dout_if.ready = 1'b0;

        // reset state and streaming
        step(2);
        chk("rst_valid", 32'(dout_if.valid), 32'd0);
        chk("rst_data", 32'(dout_if.data), 32'd0);
        chk("rst_sop_eop", 32'({dout_if.sop, dout_if.eop}), 32'd0);
        chk("rst_int_ready", 32'(in_if.ready), 32'd0);
        chk("rst_stopped", 32'(stopped), 32'd0);
        rst_n = 1'b1;
        step();
        chk("int_ready_after_rst", 32'(in_if.ready), 32'd1);
        dout_if.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(i + 1), i == 0, i == 7);
            step();
            if (i >= 1) chk("stream_valid", 32'(dout_if.valid), 32'd1);
            if (i == 1) chk("first_latency", 32'(dout_if.data), 32'd1);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        chk("stream_last", 32'({dout_if.valid, dout_if.data, dout_if.eop}), 32'({1'b1, 10'h008, 1'b1}));
        step(2);
        chk("stream_cnt", 32'(out_cnt), 32'd8);
        chk("stream_drained", 32'(sb.size()), 32'd0);

        // ready latency
        dout_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(10'h020 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        step(2);
        for (int k = 0; k < 6; k++) begin
            dout_if.ready = (k < 5) ? pat[k] : 1'b0;
            step();
            if (k < 5) chk("rl_valid", 32'(dout_if.valid), 32'(pat[k]));
        end
        chk("rl_drained", 32'(sb.size()), 32'd0);

        // full
        base = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(10'h050 + i), 1'b0, 1'b0);
            step();
        end
        chk("full_accepted", 32'(acc_cnt - base), 32'd4);
        chk("full_int_ready", 32'(in_if.ready), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0);
        dout_if.ready = 1'b1;
        step(6);
        chk("full_drained", 32'(sb.size()), 32'd0);
        chk("full_ready_back", 32'(in_if.ready), 32'd1);

        // stop mid-packet
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, w4[i], se4[i][1], se4[i][0]);
            step();
            if (i == 2) stop = 1'b1;
            if (i == 4) chk("stopping_not_stopped", 32'(stopped), 32'd0);
            if (i == 5) begin
                chk("stop_at_eop", 32'(stopped), 32'd1);
                chk("stop_last_word", 32'({dout_if.valid, dout_if.data, dout_if.eop}), 32'({1'b1, 10'h104, 1'b1}));
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stopped_hold", 32'({dout_if.valid, stopped}), 32'b01);
        end
        stop = 1'b0;
        step();
        chk("resume_wait", 32'(dout_if.valid), 32'd0);
        step();
        chk("resume_word", 32'({dout_if.valid, dout_if.data, dout_if.sop}), 32'({1'b1, 10'h200, 1'b1}));
        chk("resume_stopped", 32'(stopped), 32'd0);
        step(3);
        chk("stop_drained", 32'(sb.size()), 32'd0);

        // stop between packets
        dout_if.ready = 1'b0;
        drive(1'b1, 10'h300, 1'b1, 1'b1);
        step();
        drive(1'b1, 10'h301, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        dout_if.ready = 1'b1;
        stop = 1'b1;
        step();
        chk("idle_stop", 32'({dout_if.valid, stopped}), 32'b01);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_stop_hold", 32'(dout_if.valid), 32'd0);
        end
        stop = 1'b0;
        step(4);
        chk("idle_drained", 32'(sb.size()), 32'd0);

        // async reset mid-packet
        dout_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(10'h400 + i), i == 0, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        dout_if.ready = 1'b1;
        step();
        chk("pre_reset_valid", 32'(dout_if.valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(dout_if.valid), 32'd0);
        chk("async_int_ready", 32'(in_if.ready), 32'd0);
        chk("async_stopped", 32'(stopped), 32'd0);
        sb.delete();
        base = out_cnt;
        step(2);
        rst_n = 1'b1;
        step(6);
        chk("no_stale_output", 32'(out_cnt - base), 32'd0);
        chk("post_reset_ready", 32'(in_if.ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
